// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx byte transmitter
// between NUM_REQ on-chip byte sources, one byte per grant.
//
// Ports:
//   clk_100m     system clock
//   rst_n        asynchronous active-low reset
//   req          per-requester byte valid, held until gnt
//   req_data     byte of requester i on bits [8i+7:8i]
//   req_last     (UART_ARB_LOCK_EN only) last byte of a locked burst
//   gnt          one-hot one-cycle pulse, byte accepted
//   tx_data      byte to uart_tx data_in, held until the next issue
//   tx_wr_en     one-cycle write strobe to uart_tx
//   tx_busy      busy flag from uart_tx
//   active_id    index of the last granted requester
//   busy         high while a frame is outstanding
//   err_timeout  one-cycle pulse when tx_busy never rose after an issue
//
// Optional feature: define UART_ARB_LOCK_EN to let a requester hold the
// arbiter for a multi-byte burst terminated by req_last.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                       clk_100m,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]         req_last,
`endif
  output logic [NUM_REQ-1:0]         gnt,
  output logic [7:0]                 tx_data,
  output logic                       tx_wr_en,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  output logic                       busy,
  output logic                       err_timeout
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   last;
  logic [CNT_W-1:0]  cnt;

`ifdef UART_ARB_LOCK_EN
  logic              lock_vld;
  logic [ID_W-1:0]   lock_id;
`endif

  // Unpack the flat data bus into per-requester bytes.
  logic [7:0] req_byte [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_byte[g] = req_data[8*g +: 8];
  end

  // Winner selection: first eligible requester after 'last', ascending with wrap.
  logic [NUM_REQ-1:0] elig_c;
  logic [ID_W-1:0]    pick_c;
  logic               hit_c;
  logic               lock_hit_c;

  always_comb begin
    logic [ID_W-1:0] cand;
    elig_c     = req;
    lock_hit_c = 1'b0;
    pick_c     = '0;
    hit_c      = 1'b0;
    cand       = '0;
`ifdef UART_ARB_LOCK_EN
    // A held lock narrows eligibility to its owner while it still requests.
    if (lock_vld && req[lock_id]) begin
      elig_c          = '0;
      elig_c[lock_id] = 1'b1;
      lock_hit_c      = 1'b1;
    end
`endif
    // Scan farthest-first so the nearest hit after 'last' overwrites the rest.
    for (int unsigned d = NUM_REQ; d > 0; d--) begin
      cand = ID_W'((32'(last) + d) % NUM_REQ);
      if (elig_c[cand]) begin
        pick_c = cand;
        hit_c  = 1'b1;
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= ID_W'(NUM_REQ - 1);
      cnt         <= '0;
      gnt         <= '0;
      tx_data     <= 8'h00;
      tx_wr_en    <= 1'b0;
      active_id   <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_vld    <= 1'b0;
      lock_id     <= '0;
`endif
    end else begin
      gnt         <= '0;
      tx_wr_en    <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
`ifdef UART_ARB_LOCK_EN
          // Owner dropped its request: release; this cycle's pick already covers everyone.
          if (lock_vld && !req[lock_id]) lock_vld <= 1'b0;
`endif
          if (hit_c) begin
            gnt       <= NUM_REQ'(1) << pick_c;
            tx_wr_en  <= 1'b1;
            tx_data   <= req_byte[pick_c];
            active_id <= pick_c;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= WAIT_HI;
            // Locked grants leave the round-robin pointer where it was.
            if (!lock_hit_c) last <= pick_c;
`ifdef UART_ARB_LOCK_EN
            lock_vld  <= !req_last[pick_c];
            lock_id   <= pick_c;
`endif
          end
        end
        WAIT_HI: begin
          if (tx_busy) begin
            state <= WAIT_LO;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            // Transmitter never acknowledged: drop the byte and move on.
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
`ifdef UART_ARB_LOCK_EN
            lock_vld    <= 1'b0;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned NEVER   = 32'hFFFF_FFFF;

  logic                 clk_100m = 1'b0;
  logic                 rst_n    = 1'b0;
  logic [NUM_REQ-1:0]   req      = '0;
  logic [7:0]           rq_byte [NUM_REQ] = '{default: 8'h00};
  logic [8*NUM_REQ-1:0] req_data;
`ifdef UART_ARB_LOCK_EN
  logic [NUM_REQ-1:0]   req_last = '0;
`endif
  logic [NUM_REQ-1:0]   gnt;
  logic [7:0]           tx_data;
  logic                 tx_wr_en;
  logic                 tx_busy;
  logic [ID_W-1:0]      active_id;
  logic                 busy;
  logic                 err_timeout;

  int n_err = 0;
  int n_chk = 0;
  int tcyc  = 0;

  always #5 clk_100m = ~clk_100m;
  always @(posedge clk_100m) tcyc <= tcyc + 1;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign req_data[8*g +: 8] = rq_byte[g];
  end

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk_100m   (clk_100m),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
`ifdef UART_ARB_LOCK_EN
    .req_last   (req_last),
`endif
    .gnt        (gnt),
    .tx_data    (tx_data),
    .tx_wr_en   (tx_wr_en),
    .tx_busy    (tx_busy),
    .active_id  (active_id),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, tcyc, obs, exp);
    end
  endtask

  // uart_tx stand-in: busy for busy_len cycles after each accepted write.
  int unsigned busy_len = 1;
  bit          stuck    = 1'b0;
  bit          rnd_uart = 1'b0;
  int unsigned busy_cnt = 0;
  assign tx_busy = (busy_cnt != 0);
  always @(posedge clk_100m) begin
    if (tx_wr_en && !stuck && !(rnd_uart && $urandom_range(9) == 0))
      busy_cnt <= rnd_uart ? $urandom_range(6, 1) : busy_len;
    else if (busy_cnt != 0)
      busy_cnt <= busy_cnt - 1;
  end

  // Requesters: each presents the head of its byte queue until granted.
  logic [8:0]  fifo [NUM_REQ][64];
  int unsigned wp [NUM_REQ] = '{default: 0};
  int unsigned rp [NUM_REQ] = '{default: 0};

  always @(negedge clk_100m) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i] && wp[i] != rp[i]) rp[i]++;
      if (wp[i] != rp[i]) begin
        req[i]      = 1'b1;
        rq_byte[i]  = fifo[i][6'(rp[i])][7:0];
`ifdef UART_ARB_LOCK_EN
        req_last[i] = fifo[i][6'(rp[i])][8];
`endif
      end else begin
        req[i] = 1'b0;
      end
    end
  end

  task automatic push(input int i, input bit lst, input logic [7:0] b);
    fifo[i][6'(wp[i])] = {lst, b};
    wp[i]++;
  endtask

  // Grant log for ordering checks.
  int         gnt_log [$];
  logic [7:0] dat_log [$];
  always @(negedge clk_100m) begin
    if (rst_n && gnt != '0) begin
      for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) gnt_log.push_back(i);
      dat_log.push_back(tx_data);
    end
  end

  // Reference model: timeline of when the arbiter is free plus round-robin choice.
  logic [NUM_REQ-1:0] exp_gnt;
  logic               exp_wr, exp_busy, exp_err;
  logic [7:0]         exp_data;
  logic [ID_W-1:0]    exp_id;
  int unsigned        mcyc = 0, m_free = 0, m_issue = 0;
  bit                 m_wait_rise, m_found, m_keep, m_lock;
  logic [ID_W-1:0]    m_last, m_k, m_lock_id;
  logic [NUM_REQ-1:0] m_elig;

  always @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      exp_gnt = '0; exp_wr = 0; exp_busy = 0; exp_err = 0; exp_data = 8'h00; exp_id = '0;
      m_free = 0; m_wait_rise = 0; m_lock = 0; m_lock_id = '0;
      m_last = ID_W'(NUM_REQ - 1);
    end else begin
      exp_gnt = '0; exp_wr = 0; exp_err = 0;
      if (mcyc >= m_free) begin
        m_elig = req; m_keep = 0;
`ifdef UART_ARB_LOCK_EN
        if (m_lock) begin
          if (req[m_lock_id]) begin
            m_elig = '0; m_elig[m_lock_id] = 1'b1; m_keep = 1;
          end else begin
            m_lock = 0;
          end
        end
`endif
        m_found = 0;
        for (int d = 1; d <= int'(NUM_REQ) && !m_found; d++) begin
          m_k = ID_W'((int'(m_last) + d) % int'(NUM_REQ));
          if (m_elig[m_k]) m_found = 1;
        end
        if (m_found) begin
          exp_gnt[m_k] = 1'b1; exp_wr = 1; exp_busy = 1;
          exp_data = rq_byte[m_k]; exp_id = m_k;
          if (!m_keep) m_last = m_k;
`ifdef UART_ARB_LOCK_EN
          m_lock = !req_last[m_k]; m_lock_id = m_k;
`endif
          m_issue = mcyc + 1; m_free = NEVER; m_wait_rise = 1;
        end
      end else if (m_wait_rise) begin
        if (tx_busy) m_wait_rise = 0;
        else if (mcyc + 1 == m_issue + TIMEOUT) begin
          exp_err = 1; exp_busy = 0; m_free = mcyc + 1; m_lock = 0;
        end
      end else if (!tx_busy) begin
        exp_busy = 0; m_free = mcyc + 1;
      end
      mcyc++;
    end
  end

  always @(negedge clk_100m) begin
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("tx_wr_en", 32'(tx_wr_en), 32'(exp_wr));
    check("tx_data", 32'(tx_data), 32'(exp_data));
    check("active_id", 32'(active_id), 32'(exp_id));
    check("busy", 32'(busy), 32'(exp_busy));
    check("err_timeout", 32'(err_timeout), 32'(exp_err));
  end

  task automatic tick();
    @(negedge clk_100m);
    #1;
  endtask

  task automatic wait_gnt(input int lim, output int at);
    int n = 0;
    while (gnt == '0 && n < lim) begin tick(); n++; end
    check("gnt_arrives", 32'(gnt != '0), 1);
    at = tcyc;
  endtask

  task automatic wait_idle(input int lim, output int at);
    int n = 0;
    while (busy && n < lim) begin tick(); n++; end
    check("busy_clears", 32'(busy), 0);
    at = tcyc;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    bit done = 0;
    while (!done && n < lim) begin
      done = (busy == 1'b0) && (req == '0);
      for (int i = 0; i < NUM_REQ; i++) if (wp[i] != rp[i]) done = 0;
      if (!done) begin tick(); n++; end
    end
    check("drain", 32'(done), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 0);
    check({tag, "_wr"}, 32'(tx_wr_en), 0);
    check({tag, "_data"}, 32'(tx_data), 0);
    check({tag, "_id"}, 32'(active_id), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_err"}, 32'(err_timeout), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, g, t, e, w, f, n;
    // Reset and first grant
    rst_n = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    busy_len = 1041;
    push(0, 1'b1, 8'h55);
    c = -1;
    for (int k = 0; k < 5 && c < 0; k++) begin tick(); if (req[0]) c = tcyc; end
    wait_gnt(5, g);
    check("t1_latency", 32'(g - c), 1);
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_wr_en", 32'(tx_wr_en), 1);
    check("t1_data", 32'(tx_data), 32'h55);
    wait_idle(1200, t);
    check("t1_busy_span", 32'(t - g), 1043);

    // Fairness with all four requesting
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    busy_len = 3;
    gnt_log.delete(); dat_log.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_REQ; i++) push(i, 1'b1, 8'(8'hA0 + i));
    n = 0;
    while (gnt_log.size() < 8 && n < 200) begin tick(); n++; end
    check("t2_count", 32'(gnt_log.size() >= 8), 1);
    for (int j = 0; j < 5 && j < gnt_log.size(); j++) begin
      check("t2_order", 32'(gnt_log[j]), 32'(j % 4));
      check("t2_data", 32'(dat_log[j]), 32'(8'hA0 + j % 4));
    end
    drain(200);

    // Request arriving while the previous frame is in flight
    busy_len = 5;
    push(0, 1'b1, 8'h5A);
    wait_gnt(5, g);
    tick(); tick();
    push(2, 1'b1, 8'h77);
    n = 0;
    while (tx_busy && n < 20) begin tick(); n++; end
    f = tcyc;
    n = 0;
    while (!gnt[2] && n < 10) begin tick(); n++; end
    check("t3_gnt2", 32'(gnt[2]), 1);
    check("t3_latency", 32'(tcyc - f), 2);
    check("t3_data", 32'(tx_data), 32'h77);
    drain(100);

    // Transmitter never goes busy
    stuck = 1'b1;
    push(1, 1'b1, 8'h31);
    wait_gnt(5, w);
    push(3, 1'b1, 8'h33);
    n = 0;
    while (!err_timeout && n < 40) begin tick(); n++; end
    e = tcyc;
    check("t4_err", 32'(err_timeout), 1);
    check("t4_err_delay", 32'(e - w), 16);
    check("t4_busy_at_err", 32'(busy), 0);
    tick();
    check("t4_next_gnt", 32'(gnt), 32'h8);
    check("t4_next_data", 32'(tx_data), 32'h33);
    n = 0;
    while (!err_timeout && n < 40) begin tick(); n++; end
    check("t4_err2", 32'(err_timeout), 1);
    stuck = 1'b0;
    drain(100);

    // Reset in the middle of a frame
    busy_len = 20;
    push(2, 1'b1, 8'h42);
    wait_gnt(5, g);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check_reset_outputs("t5");
    rst_n = 1'b1;
    push(3, 1'b1, 8'h93);
    push(0, 1'b1, 8'h90);
    wait_gnt(5, g);
    check("t5_gnt", 32'(gnt), 32'h1);
    check("t5_data", 32'(tx_data), 32'h90);
    drain(200);

`ifdef UART_ARB_LOCK_EN
    // Locked burst from requester 1 while requester 0 waits
    busy_len = 2;
    gnt_log.delete(); dat_log.delete();
    push(1, 1'b0, 8'h11);
    push(1, 1'b0, 8'h12);
    push(1, 1'b1, 8'h13);
    n = 0;
    while (gnt_log.size() < 1 && n < 10) begin tick(); n++; end
    push(0, 1'b1, 8'h20);
    n = 0;
    while (gnt_log.size() < 4 && n < 200) begin tick(); n++; end
    check("t6_count", 32'(gnt_log.size() >= 4), 1);
    for (int j = 0; j < 4 && j < gnt_log.size(); j++)
      check("t6_order", 32'(gnt_log[j]), (j < 3) ? 32'd1 : 32'd0);
    drain(100);
`endif

    // Randomized traffic, withdrawals and busy lengths
    rnd_uart = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      tick();
      if ($urandom_range(3) == 0) begin
        int i;
        i = int'($urandom_range(NUM_REQ - 1));
        if (wp[i] - rp[i] < 6) push(i, 1'($urandom_range(1)), 8'($urandom));
      end
      if ($urandom_range(63) == 0) begin
        int i;
        i = int'($urandom_range(NUM_REQ - 1));
        rp[i] = wp[i];
      end
    end
    rnd_uart = 1'b0;
    drain(3000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_tx` byte transmitter between `NUM_REQ` on-chip requesters, such as a debug console, a status reporter and a register-dump engine. Arbitration is round-robin, one byte per grant. The block issues a one-cycle `wr_en` to the transmitter and then tracks its `tx_busy` through a full frame before issuing the next byte. It sits between the fabric-side byte sources and the single `uart_tx` instance driving the board TX pin.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 16: maximum cycles to wait for `tx_busy` to rise after an issue.

Ports:
- `clk_100m` input 1: system clock.
- `rst_n` input 1: reset. One clock; reset is asynchronous and active-low.
- `req` input NUM_REQ: per-requester byte-valid; held until its `gnt`.
- `req_data` input 8*NUM_REQ: byte of requester i on bits [8i+7:8i]; stable while `req[i]` is high.
- `gnt` output NUM_REQ: one-hot, one-cycle pulse; the byte of that requester was accepted.
- `tx_data` output 8: byte to `uart_tx` `data_in`.
- `tx_wr_en` output 1: one-cycle write strobe to `uart_tx`.
- `tx_busy` input 1: from `uart_tx`.
- `active_id` output clog2(NUM_REQ): index of the last granted requester.
- `busy` output 1: high whenever state is not IDLE.
- `err_timeout` output 1: one-cycle pulse when `tx_busy` failed to rise.

## Operation
- All outputs are registered. Reset values: `gnt`=0, `tx_data`=0x00, `tx_wr_en`=0, `active_id`=0, `busy`=0, `err_timeout`=0.
- The round-robin pointer `last` resets to NUM_REQ-1, so requester 0 wins first.
- The FSM has states IDLE, WAIT_HI and WAIT_LO. It resets to IDLE.
- **IDLE:**
  - The block searches `req` starting at index (`last`+1) mod NUM_REQ, ascending with wrap.
  - On the first hit k, the next edge sets: `gnt[k]`=1, `tx_wr_en`=1, `tx_data`=`req_data[k]`, `active_id`=k, `last`=k, timeout counter=0, and moves to WAIT_HI.
  - With no request, the block stays in IDLE.
- **WAIT_HI:**
  - `tx_busy`=1 → WAIT_LO.
  - Otherwise the counter increments. When counter==TIMEOUT-1, the block pulses `err_timeout` and returns to IDLE. The byte counts as consumed and is not retried.
- **WAIT_LO:** `tx_busy`=0 → IDLE.
- `req` is ignored outside IDLE. A requester that raises `req` mid-frame waits; it is never lost.
- Simultaneous requests resolve strictly by pointer order. A requester is skipped at most NUM_REQ-1 times.
- A requester dropping `req` before `gnt` withdraws cleanly. No grant is issued to a deasserted line.
- Asserting `rst_n` mid-frame aborts immediately. The transmitter is not signalled; its current frame completes on its own.

## Timing
- Request latency: `req` sampled high in IDLE → `gnt` and `tx_wr_en` high on the next cycle, for exactly one cycle.
- `tx_data` is held from the issue cycle until the next issue.
- Minimum spacing between `tx_wr_en` pulses: 3 cycles plus the high time of `tx_busy`.
- Timeout: `err_timeout` is asserted TIMEOUT cycles after `tx_wr_en`. IDLE is re-entered the same cycle.
- `busy` is high from the `tx_wr_en` cycle through the cycle WAIT_LO sees `tx_busy`=0.

## Configuration
- `UART_ARB_LOCK_EN` defined:
  - Adds input `req_last` (NUM_REQ), valid with `req`.
  - A grant taken with `req_last[k]`=0 locks the arbiter to k: only k is eligible in IDLE, and the pointer does not advance.
  - The lock clears when:
    - a byte from k with `req_last[k]`=1 is granted;
    - `err_timeout` fires;
    - k has `req` low in IDLE. In that case arbitration proceeds over all requesters in the same cycle.
  - The lock resets to clear.
- Not defined: the port is absent and arbitration is pure per-byte round-robin.

## Test plan
- **Reset and first grant:** after reset, `req`=4'b0001 with byte 0x55; model `uart_tx` holds busy 1041 cycles → `gnt`=0001 and `tx_wr_en` one cycle later, `tx_data`=0x55, `busy` falls after `tx_busy` falls.
- **Fairness:** `req`=4'b1111 held continuously with bytes 0xA0..0xA3 → grant order 0,1,2,3,0 and `tx_data` matches each owner.
- **Mid-frame arrival:** `req[2]` raised during WAIT_LO of requester 0's byte → `gnt[2]` exactly 1 cycle after `tx_busy` falls plus 1.
- **Timeout:** `tx_busy` tied 0, TIMEOUT=16 → `err_timeout` pulse 16 cycles after `tx_wr_en`, then the next pending request is granted.
- **Reset mid-frame:** pulse `rst_n` low in WAIT_LO → all outputs at reset values, next grant goes to requester 0.
- **`UART_ARB_LOCK_EN`:** requester 1 sends 3 bytes with `req_last`=0,0,1 while `req[0]` is held → all three bytes from 1, then 0 is granted.
